// File: rtl/miner_pkg.sv
// Shared types and constants for the nonce scheduler and its watchdog.
package miner_pkg;

  localparam int NONCE_W_DEFAULT = 32;
  localparam int HASH_W_DEFAULT  = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_DRAIN,
    S_FOUND,
    S_EXHAUSTED,
    S_TIMEOUT
  } sched_state_t;

  localparam logic [2:0] STAT_IDLE      = 3'd0;
  localparam logic [2:0] STAT_BUSY      = 3'd1;
  localparam logic [2:0] STAT_EXHAUSTED = 3'd2;
  localparam logic [2:0] STAT_FOUND     = 3'd3;
  localparam logic [2:0] STAT_TIMEOUT   = 3'd4;

endpackage

// File: rtl/miner_watchdog.sv
// Clear/enable cycle counter; tc flags the enabled cycle whose count step reaches TIMEOUT-1.
module miner_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  assign tc = en && (cnt == W'(TIMEOUT - 2));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Walks a nonce range through one shared SHA core, stopping on hit, range end, core timeout or abort.
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEFAULT,
  parameter int HASH_W  = HASH_W_DEFAULT,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [HASH_W-1:0]  target,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] nonce_limit,
  output logic               sha_start,
  output logic [NONCE_W-1:0] sha_nonce,
  input  logic               sha_done,
  input  logic [HASH_W-1:0]  sha_hash,
  output logic [2:0]         status,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [31:0]        hash_count
);

  // Core handshake: sha_start is a one-cycle request with sha_nonce held until the
  // matching one-cycle sha_done; exactly one request is outstanding at a time.
  sched_state_t        state;
  logic [HASH_W-1:0]   target_reg;
  logic [HASH_W-1:0]   hash_reg;
  logic [NONCE_W-1:0]  limit_reg;
  logic [NONCE_W-1:0]  nonce;
  logic                wd_tc;

  miner_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (state == S_ISSUE),
    .en    ((state == S_WAIT) || (state == S_DRAIN)),
    .tc    (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      target_reg  <= '0;
      hash_reg    <= '0;
      limit_reg   <= '0;
      nonce       <= '0;
      sha_start   <= 1'b0;
      sha_nonce   <= '0;
      status      <= STAT_IDLE;
      found_nonce <= '0;
      hash_count  <= '0;
    end else begin
      sha_start <= 1'b0;
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_TIMEOUT: begin
          if (abort) begin
            state  <= S_IDLE;
            status <= STAT_IDLE;
          end else if (start) begin
            target_reg <= target;
            limit_reg  <= nonce_limit;
            nonce      <= nonce_base;
            hash_count <= '0;
            if (nonce_base > nonce_limit) begin
              state  <= S_EXHAUSTED;
              status <= STAT_EXHAUSTED;
            end else begin
              state     <= S_ISSUE;
              status    <= STAT_BUSY;
              sha_start <= 1'b1;
              sha_nonce <= nonce_base;
            end
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state  <= S_IDLE;
            status <= STAT_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            // A result arriving with the abort is simply dropped; otherwise drain the core.
            state  <= sha_done ? S_IDLE : S_DRAIN;
            status <= sha_done ? STAT_IDLE : STAT_BUSY;
          end else if (sha_done) begin
            hash_reg <= sha_hash;
            if (hash_count != '1) hash_count <= hash_count + 32'd1;
            state <= S_COMPARE;
          end else if (wd_tc) begin
            state  <= S_TIMEOUT;
            status <= STAT_TIMEOUT;
          end
        end
        S_COMPARE: begin
          if (abort) begin
            state  <= S_IDLE;
            status <= STAT_IDLE;
          end else if (hash_reg < target_reg) begin
            found_nonce <= nonce;
            state       <= S_FOUND;
            status      <= STAT_FOUND;
          end else if (nonce == limit_reg) begin
            state  <= S_EXHAUSTED;
            status <= STAT_EXHAUSTED;
          end else begin
            nonce     <= nonce + NONCE_W'(1);
            sha_nonce <= nonce + NONCE_W'(1);
            sha_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (sha_done) begin
            state  <= S_IDLE;
            status <= STAT_IDLE;
          end else if (wd_tc) begin
            state  <= S_TIMEOUT;
            status <= STAT_TIMEOUT;
          end
        end
        default: begin
          state  <= S_IDLE;
          status <= STAT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a fixed-latency SHA core stub and a range-walk reference model.
module tb_nonce_scheduler;

  localparam int NW  = 32;
  localparam int HW  = 256;
  localparam int TO  = 1024;
  localparam int LAT = 66;

  localparam logic [HW-1:0] TGT      = {4'h1, {(HW-4){1'b0}}};
  localparam logic [HW-1:0] HIT_HASH = {4'h0, {(HW-4){1'b1}}};
  localparam logic [HW-1:0] ALL_ONES = {HW{1'b1}};

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [HW-1:0] target;
  logic [NW-1:0] nonce_base;
  logic [NW-1:0] nonce_limit;
  logic          sha_start;
  logic [NW-1:0] sha_nonce;
  logic          sha_done;
  logic [HW-1:0] sha_hash;
  logic [2:0]    status;
  logic [NW-1:0] found_nonce;
  logic [31:0]   hash_count;

  int checks;
  int errors;
  int cyc;
  int n_starts;
  int prev_cyc;
  bit have_prev;
  int stub_mode;   // 0 never below target, 1 hit at nonce 3, 2 hash equals target, 3 withhold done
  int stub_cnt;
  logic [NW-1:0] stub_nonce;
  logic [NW-1:0] exp_q[$];

  nonce_scheduler #(.NONCE_W(NW), .HASH_W(HW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .target      (target),
    .nonce_base  (nonce_base),
    .nonce_limit (nonce_limit),
    .sha_start   (sha_start),
    .sha_nonce   (sha_nonce),
    .sha_done    (sha_done),
    .sha_hash    (sha_hash),
    .status      (status),
    .found_nonce (found_nonce),
    .hash_count  (hash_count)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [HW-1:0] stub_hash(input logic [NW-1:0] n);
    case (stub_mode)
      1:       return (n == 3) ? HIT_HASH : ALL_ONES;
      2:       return TGT;
      default: return ALL_ONES;
    endcase
  endfunction

  // SHA core stub: done is high in the LAT-th cycle after the start cycle.
  initial begin
    sha_done = 1'b0;
    sha_hash = '0;
    stub_cnt = 0;
    stub_nonce = '0;
    forever begin
      @(posedge clk);
      #1;
      sha_done = 1'b0;
      if (rst) begin
        stub_cnt = 0;
      end else begin
        if (stub_cnt > 0) begin
          stub_cnt--;
          if (stub_cnt == 0) begin
            sha_done = 1'b1;
            sha_hash = stub_hash(stub_nonce);
          end
        end
        if (sha_start && stub_mode != 3) begin
          stub_cnt   = LAT;
          stub_nonce = sha_nonce;
        end
      end
    end
  end

  // scoreboard: every start pulse must carry the next expected nonce at the expected period
  initial begin
    logic [NW-1:0] exp;
    forever begin
      @(negedge clk);
      if (sha_start === 1'b1) begin
        n_starts++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL issue_nonce: got unexpected sha_start nonce %0h, required none", sha_nonce);
        end else begin
          exp = exp_q.pop_front();
          if (sha_nonce !== exp) begin
            errors++;
            $display("FAIL issue_nonce: got %0h required %0h", sha_nonce, exp);
          end
        end
        if (have_prev) begin
          checks++;
          if (cyc - prev_cyc != LAT + 2) begin
            errors++;
            $display("FAIL nonce_period: got %0d required %0d", cyc - prev_cyc, LAT + 2);
          end
        end
        prev_cyc  = cyc;
        have_prev = 1'b1;
        checks++;
        if (status !== 3'd1) begin
          errors++;
          $display("FAIL busy_on_issue: got status %0d required 1", status);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_status"},      64'(status),      64'd0);
    check({tag, "_sha_start"},   64'(sha_start),   64'd0);
    check({tag, "_sha_nonce"},   64'(sha_nonce),   64'd0);
    check({tag, "_found_nonce"}, 64'(found_nonce), 64'd0);
    check({tag, "_hash_count"},  64'(hash_count),  64'd0);
  endtask

  // reference: walk the range with plain arithmetic, queueing each nonce to be issued
  task automatic model_search(input logic [NW-1:0] b, input logic [NW-1:0] l,
                              input logic [HW-1:0] t, output logic [2:0] st,
                              output logic [NW-1:0] fn, output logic [31:0] cnt);
    logic [NW:0] n;
    bit fin;
    st = 3'd2;
    fn = '0;
    cnt = '0;
    if (b <= l) begin
      n = {1'b0, b};
      fin = 1'b0;
      while (!fin) begin
        exp_q.push_back(n[NW-1:0]);
        cnt++;
        if (stub_hash(n[NW-1:0]) < t) begin
          st = 3'd3;
          fn = n[NW-1:0];
          fin = 1'b1;
        end else if (n[NW-1:0] == l) begin
          fin = 1'b1;
        end else begin
          n++;
        end
      end
    end
  endtask

  task automatic pulse_start(input logic [HW-1:0] t, input logic [NW-1:0] b, input logic [NW-1:0] l);
    @(negedge clk);
    start       = 1'b1;
    target      = t;
    nonce_base  = b;
    nonce_limit = l;
    have_prev   = 1'b0;
    n_starts    = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_not_busy(input string name, input int budget);
    int k;
    k = 0;
    while (status === 3'd1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (status === 3'd1) begin
      errors++;
      $display("FAIL %s_bound: got still busy after %0d cycles, required terminal", name, budget);
    end
  endtask

  task automatic wait_issue(input string name, input logic [NW-1:0] n, input int budget);
    int k;
    k = 0;
    while (!(sha_start === 1'b1 && sha_nonce === n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(sha_start === 1'b1 && sha_nonce === n)) begin
      errors++;
      $display("FAIL %s_issue_bound: got no sha_start for nonce %0h, required one", name, n);
    end
  endtask

  task automatic run_search(input string name, input logic [HW-1:0] t,
                            input logic [NW-1:0] b, input logic [NW-1:0] l);
    logic [2:0]    st;
    logic [NW-1:0] fn;
    logic [31:0]   cnt;
    model_search(b, l, t, st, fn, cnt);
    pulse_start(t, b, l);
    wait_not_busy(name, 2000);
    check({name, "_status"}, 64'(status), 64'(st));
    check({name, "_count"}, 64'(hash_count), 64'(cnt));
    if (st == 3'd3) check({name, "_found"}, 64'(found_nonce), 64'(fn));
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int t0;
    int k;
    checks = 0;
    errors = 0;
    n_starts = 0;
    have_prev = 1'b0;
    prev_cyc = 0;
    stub_mode = 0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    target = '0;
    nonce_base = '0;
    nonce_limit = '0;

    // reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // hit at nonce 3
    stub_mode = 1;
    run_search("hit3", TGT, 32'd0, 32'd10);
    check("hit3_lit_status", 64'(status), 64'd3);
    check("hit3_lit_found", 64'(found_nonce), 64'd3);
    check("hit3_lit_count", 64'(hash_count), 64'd4);
    check("hit3_lit_starts", 64'(n_starts), 64'd4);

    // abort in a terminal state keeps found_nonce
    pulse_abort();
    check("term_abort_status", 64'(status), 64'd0);
    check("term_abort_found", 64'(found_nonce), 64'd3);

    // top-of-range: no wrap
    stub_mode = 0;
    run_search("top", TGT, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    check("top_lit_status", 64'(status), 64'd2);
    check("top_lit_count", 64'(hash_count), 64'd2);
    check("top_last_nonce", 64'(sha_nonce), 64'hFFFF_FFFF);

    // empty range
    stub_mode = 2;
    pulse_start(TGT, 32'd5, 32'd4);
    check("empty_status", 64'(status), 64'd2);
    check("empty_count", 64'(hash_count), 64'd0);
    repeat (3) @(negedge clk);
    check("empty_starts", 64'(n_starts), 64'd0);

    // hash equal to target is not a hit
    run_search("equal", TGT, 32'd7, 32'd7);
    check("equal_lit_status", 64'(status), 64'd2);

    // abort while waiting on nonce 2: drain, then idle
    stub_mode = 0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    pulse_start(TGT, 32'd0, 32'd10);
    wait_issue("abort_wait", 32'd2, 400);
    t0 = cyc;
    repeat (10) @(negedge clk);
    pulse_abort();
    check("drain_status", 64'(status), 64'd1);
    wait_not_busy("drain", 200);
    check("drain_idle_at", 64'(cyc - t0), 64'(LAT + 1));
    check("drain_status_idle", 64'(status), 64'd0);
    check("drain_count", 64'(hash_count), 64'd2);

    // abort coincident with sha_done
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    pulse_start(TGT, 32'd0, 32'd10);
    k = 0;
    while (!(sha_done === 1'b1 && sha_nonce === 32'd1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("coinc_seen_done", 64'(sha_done), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("coinc_status", 64'(status), 64'd0);
    check("coinc_count", 64'(hash_count), 64'd1);
    repeat (80) @(negedge clk);
    check("coinc_drained", 64'(exp_q.size()), 64'd0);

    // core timeout
    stub_mode = 3;
    exp_q.push_back(32'd20);
    pulse_start(TGT, 32'd20, 32'd30);
    wait_issue("tmo", 32'd20, 10);
    t0 = cyc;
    wait_not_busy("tmo", 1100);
    check("tmo_status", 64'(status), 64'd4);
    check("tmo_latency", 64'(cyc - t0), 64'(TO));
    check("tmo_count", 64'(hash_count), 64'd0);

    // restart after timeout
    stub_mode = 0;
    run_search("restart", TGT, 32'd20, 32'd21);

    // start while busy is ignored
    stub_mode = 1;
    begin
      logic [2:0] st;
      logic [NW-1:0] fn;
      logic [31:0] cnt;
      model_search(32'd0, 32'd10, TGT, st, fn, cnt);
      pulse_start(TGT, 32'd0, 32'd10);
      wait_issue("busy_start", 32'd1, 400);
      repeat (5) @(negedge clk);
      start = 1'b1;
      target = '0;
      nonce_base = 32'd100;
      nonce_limit = 32'd200;
      @(negedge clk);
      start = 1'b0;
      wait_not_busy("busy_start", 2000);
      check("busy_start_status", 64'(status), 64'(st));
      check("busy_start_found", 64'(found_nonce), 64'(fn));
      check("busy_start_count", 64'(hash_count), 64'(cnt));
    end

    // reset mid-wait
    stub_mode = 0;
    exp_q.push_back(32'd0);
    pulse_start(TGT, 32'd0, 32'd10);
    wait_issue("rst_mid", 32'd0, 10);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("rst_mid_quiet", 64'(status), 64'd0);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
